// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the RISC-V front end.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs between instruction memory and decode.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic [1:0]      o_count,
    output logic            o_valid,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr
);

    logic [XLEN-1:0] r_pc    [2];
    logic [XLEN-1:0] r_instr [2];
    logic            r_head;
    logic [1:0]      r_count;

    logic w_pop;
    logic w_tail;

    assign w_pop  = i_pop & (r_count != 2'd0);
    // A push only happens with count <= 1, so the tail is head + count mod 2.
    assign w_tail = r_head ^ r_count[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= NOP_INSTR;
            end
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_pc[w_tail]    <= i_pc;
                r_instr[w_tail] <= i_instr;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_count      = r_count;
    assign o_valid      = (r_count != 2'd0);
    assign o_head_pc    = r_pc[r_head];
    assign o_head_instr = r_instr[r_head];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the pc, issues reads to a 1-cycle synchronous imem,
// tracks the single outstanding read and queues responses for decode.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
)(
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_ready
);

    localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;

    logic [1:0]      w_count;
    logic [2:0]      w_used;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_used        = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_pop         = fetch_valid & fetch_ready;
    // A slot freed by this cycle's pop may be re-spent on a new issue.
    assign w_issue       = redirect_valid | (w_used < CREDITS) |
                           ((w_used == CREDITS) & w_pop);
    assign w_push        = r_inflight & ~redirect_valid;

    assign imem_addr = redirect_valid ? (w_redirect_pc >> 2) : (r_pc >> 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_redirect_pc;
            r_pc          <= w_redirect_pc + 32'd4;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .i_pc         (r_inflight_pc),
        .i_instr      (imem_rdata),
        .o_count      (w_count),
        .o_valid      (fetch_valid),
        .o_head_pc    (fetch_pc),
        .o_head_instr (fetch_instr)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed cycle table,
// hand-written corner sequences and a randomized in-order stream scoreboard.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds 32'h1000_0000 + k, one-cycle read latency.
    always_ff @(posedge clk) imem_rdata <= 32'h1000_0000 + imem_addr;

    function automatic logic [31:0] word_at(input logic [31:0] byte_pc);
        return 32'h1000_0000 + (byte_pc >> 2);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream scoreboard state: in-order pcs accepted by decode.
    logic [31:0] exp_pc;
    bit          after_redir;
    bit          prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          idle;
    int          accepts;
    bit          last_acc;
    logic [31:0] last_acc_pc;

    task automatic sb_clear();
        exp_pc      = 32'h0;
        after_redir = 1'b0;
        prev_hold   = 1'b0;
        idle        = 0;
        accepts     = 0;
        last_acc    = 1'b0;
    endtask

    task automatic step(input logic i_rv, input logic [31:0] i_rpc, input logic i_rdy);
        @(negedge clk);
        redirect_valid = i_rv;
        redirect_pc    = i_rpc;
        fetch_ready    = i_rdy;
        #1;
        if (after_redir) check("post_redirect_valid", 32'(fetch_valid), 32'd0);
        if (prev_hold) begin
            check("hold_valid", 32'(fetch_valid), 32'd1);
            check("hold_pc", fetch_pc, prev_pc);
            check("hold_instr", fetch_instr, prev_instr);
        end
        last_acc = 1'b0;
        if (fetch_valid && i_rdy) begin
            check("stream_pc", fetch_pc, exp_pc);
            check("stream_instr", fetch_instr, word_at(exp_pc));
            last_acc    = 1'b1;
            last_acc_pc = fetch_pc;
            exp_pc      = exp_pc + 32'd4;
            accepts++;
            idle = 0;
        end else if (i_rdy) begin
            idle++;
            check("liveness", 32'(idle <= 3), 32'd1);
        end
        after_redir = i_rv;
        prev_hold   = fetch_valid && !i_rdy && !i_rv;
        prev_pc     = fetch_pc;
        prev_instr  = fetch_instr;
        if (i_rv) begin
            exp_pc = i_rpc & ~32'h3;
            idle   = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
        check({tag, "_instr"}, fetch_instr, 32'h0000_0013);
        check({tag, "_pc"}, fetch_pc, 32'h0);
        check({tag, "_addr"}, imem_addr, 32'h0);
    endtask

    // Holds reset for two cycles, releases between edges so the next negedge is cycle 0.
    task automatic release_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        sb_clear();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fetch_ready    = 1'b0;
        release_reset();
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fetch_ready    = 1'b0;
        sb_clear();
        #1;
        check_reset_outputs("reset_init");

        // Cycle-exact from reset release: startup, 3 cycles of backpressure, redirect with pop.
        vecs[0]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0,         32'h00};
        vecs[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0,         32'h01};
        vecs[2]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 32'h1000_0000, 32'h02};
        vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 32'h1000_0001, 32'h03};
        vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 32'h1000_0001, 32'h03};
        vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 32'h1000_0001, 32'h03};
        vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 32'h1000_0002, 32'h04};
        vecs[7]  = '{1'b1, 32'h42, 1'b1, 1'b1, 32'h0C, 32'h1000_0003, 32'h10};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0,         32'h11};
        vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h40, 32'h1000_0010, 32'h12};
        vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h44, 32'h1000_0011, 32'h13};

        release_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            fetch_ready    = vecs[i].rdy;
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].ev));
            check($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                check($sformatf("tbl%0d_pc", i), fetch_pc, vecs[i].epc);
                check($sformatf("tbl%0d_instr", i), fetch_instr, vecs[i].einstr);
            end
        end

        // Throughput with ready held high, then 5 cycles of backpressure and resume.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1);
        check("throughput_accepts", 32'(accepts), 32'd18);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect while the queue is full, then continue.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0042, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: only the second target stream survives.
        step(1'b1, 32'h0000_0008, 1'b1);
        step(1'b1, 32'h0000_0020, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect coincident with a pop.
        check("pop_redirect_pre_valid", 32'(fetch_valid), 32'd1);
        step(1'b1, 32'h0000_0100, 1'b1);
        check("pop_redirect_accepted", 32'(last_acc), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // Address wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Asynchronous reset while streaming at pc 12.
        do_reset();
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                step(1'b0, 32'h0, 1'b1);
                if (last_acc && last_acc_pc == 32'h0000_000C) found = 1'b1;
            end
            check("found_pc12", 32'(found), 32'd1);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("pre_reset_valid", 32'(fetch_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        fetch_ready = 1'b0;
        release_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        check("restart_accepts", 32'(accepts), 32'd6);

        // Randomized stream with backpressure and redirects.
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom) : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
            rdy = ($urandom_range(0, 3) != 0);
            step(rv, rpc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
